// File: rtl/jtag_sys_pkg.sv
// Shared types for the JTAG system reset controller.
// State encodings and counter width helper.
package jtag_sys_pkg;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_DELAY = 2'd1,
      ST_RUN   = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   function automatic int cnt_w(input int hold, input int dly);
      int m;
      m = (hold > dly) ? hold : dly;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/jtag_sync_bit.sv
// Multi-flop synchroniser for one asynchronous control bit.
// Chain clears to 0 under the synchronous active-low reset.
module jtag_sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (!reset)
         chain <= '0;
      else
         chain <= {chain[SYNC_STAGES-2:0], d};
   end

   assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_sys_reset_ctrl.sv
// JTAG-driven system reset stretcher and CPU enable sequencer.
// Produces a clean reset -> settle -> run sequence in the clk domain.
module jtag_sys_reset_ctrl
   import jtag_sys_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int RST_HOLD_CYC = 16,
   parameter int CPU_EN_DELAY = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       jtag_system_reset,
   input  logic       jtag_cpu_en,
   output logic       sys_reset,
   output logic       cpu_en,
   output logic       reset_done,
   output logic [1:0] state
);

   localparam int CNT_W = cnt_w(RST_HOLD_CYC, CPU_EN_DELAY);
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(RST_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] DLY_LD  = CNT_W'(CPU_EN_DELAY - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic             rst_s;
   logic             en_s;
   state_t           state_q;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nx;
   logic             done_nx;
   logic             sys_nx;
   logic             en_nx;

   jtag_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rst (
      .clk   (clk),
      .reset (reset),
      .d     (jtag_system_reset),
      .q     (rst_s)
   );

   jtag_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
      .clk   (clk),
      .reset (reset),
      .d     (jtag_cpu_en),
      .q     (en_s)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_HOLD;
         cnt_q      <= HOLD_LD;
         sys_reset  <= 1'b1;
         cpu_en     <= 1'b0;
         reset_done <= 1'b0;
      end else begin
         state_q    <= state_nx;
         cnt_q      <= cnt_nx;
         sys_reset  <= sys_nx;
         cpu_en     <= en_nx;
         reset_done <= done_nx;
      end
   end

   // A synchronised reset request overrides every other transition.
   always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
      done_nx  = 1'b0;
      if (rst_s) begin
         state_nx = ST_HOLD;
         cnt_nx   = HOLD_LD;
      end else begin
         unique case (state_q)
            ST_HOLD: begin
               if (cnt_q != '0) begin
                  cnt_nx = cnt_q - ONE;
               end else begin
                  state_nx = ST_DELAY;
                  cnt_nx   = DLY_LD;
                  done_nx  = 1'b1;
               end
            end
            ST_DELAY: begin
               if (cnt_q != '0)
                  cnt_nx = cnt_q - ONE;
               else
                  state_nx = en_s ? ST_RUN : ST_HALT;
            end
            ST_RUN: begin
               if (!en_s)
                  state_nx = ST_HALT;
            end
            ST_HALT: begin
               if (en_s) begin
                  state_nx = ST_DELAY;
                  cnt_nx   = DLY_LD;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      sys_nx = 1'b0;
      en_nx  = 1'b0;
      unique case (1'b1)
         (state_nx == ST_HOLD): sys_nx = 1'b1;
         (state_nx == ST_RUN):  en_nx  = 1'b1;
         default: ;
      endcase
   end

   assign state = state_q;

endmodule
